// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the sequential shifter state type.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_AMT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

endpackage : alu_pkg

// File: rtl/left_shift_step.sv
// Combinational single-bit left shift: moves every bit up one place and inserts
// fill at bit 0. It also reports the bit that leaves the MSB and whether the sign flips.
module left_shift_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic             fill,
  output logic [WIDTH-1:0] out,
  output logic             msb_out,
  output logic             ovf_step
);

  assign out      = {in[WIDTH-2:0], fill};
  assign msb_out  = in[WIDTH-1];
  // The new sign is the old bit WIDTH-2, so the sign changes when the top two bits differ.
  assign ovf_step = in[WIDTH-1] ^ in[WIDTH-2];

endmodule : left_shift_step

// File: rtl/seq_left_shifter.sv
// Multi-cycle left shifter that moves one bit per clock and uses a start/busy/done handshake.
// Define SEQ_SHIFT_ROTATE_EN to add the rotate input, which selects rotate-left.
module seq_left_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int AMT_W = ALU_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amt,
`ifdef SEQ_SHIFT_ROTATE_EN
  input  logic             rotate,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow
);

  shift_state_t     state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             rot_q, rot_d;

  logic [WIDTH-1:0] step_out;
  logic             step_msb;
  logic             step_ovf;
  logic             fill;

`ifdef SEQ_SHIFT_ROTATE_EN
  assign fill = rot_q & out_q[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  left_shift_step #(.WIDTH(WIDTH)) u_step (
    .in       (out_q),
    .fill     (fill),
    .out      (step_out),
    .msb_out  (step_msb),
    .ovf_step (step_ovf)
  );

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    rot_d   = rot_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          out_d   = in;
          cnt_d   = amt;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
          rot_d   = rotate;
`else
          rot_d   = 1'b0;
`endif
          state_d = (amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        out_d   = step_out;
        carry_d = step_msb;
        ovf_d   = ovf_q | (step_ovf & ~rot_q);
        cnt_d   = cnt_q - AMT_W'(1);
        // Leaving at cnt==1 means the down-counter can never wrap.
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register update tied to the same clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      rot_q   <= rot_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign out      = out_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule : seq_left_shifter

// File: tb/tb_seq_left_shifter.sv
// Self-checking bench for seq_left_shifter: directed cases and random operations,
// compared against an arithmetic reference model.
module tb_seq_left_shifter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in_v = '0;
  logic [2:0]   amt_v = '0;
  logic         rot_v = 1'b0;
  logic         busy, done, carry, overflow;
  logic [W-1:0] out;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_left_shifter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in       (in_v),
    .amt      (amt_v),
`ifdef SEQ_SHIFT_ROTATE_EN
    .rotate   (rot_v),
`endif
    .busy     (busy),
    .done     (done),
    .out      (out),
    .carry    (carry),
    .overflow (overflow)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the whole operation is computed in one step from the original operand.
  task automatic model(input logic [W-1:0] a, input int n, input bit rot,
                       output logic [W-1:0] o, output bit c, output bit v);
    int ai, t, mask;
    ai = int'(a);
    if (n == 0) begin
      o = a; c = 1'b0; v = 1'b0;
    end else begin
      o = rot ? W'((ai << n) | (ai >> (W - n))) : W'(ai << n);
      c = a[W - n];
      // Sign changes at some step exactly when bits W-1 down to W-1-n are not all equal.
      mask = (1 << (n + 1)) - 1;
      t = (ai >> (W - 1 - n)) & mask;
      v = !rot && (t != 0) && (t != mask);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input int n, input bit rot, input string tag);
    logic [W-1:0] eo;
    bit ec, ev;
    int lat;
    model(a, n, rot, eo, ec, ev);
    @(negedge clk);
    start = 1'b1; in_v = a; amt_v = 3'(n); rot_v = rot;
    @(posedge clk);
    #1;
    start = 1'b0; in_v = W'($urandom); amt_v = 3'($urandom); rot_v = 1'($urandom);
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (done === 1'b1 || lat > 20) break;
      check({tag, ".busy_shift"}, int'(busy), 1);
      lat++;
    end
    check({tag, ".latency"}, lat, n);
    check({tag, ".out"}, int'(out), int'(eo));
    check({tag, ".carry"}, int'(carry), int'(ec));
    check({tag, ".ovf"}, int'(overflow), int'(ev));
    check({tag, ".busy_done"}, int'(busy), 1);
    @(negedge clk);
    check({tag, ".done_clr"}, int'(done), 0);
    check({tag, ".busy_clr"}, int'(busy), 0);
    check({tag, ".out_hold"}, int'(out), int'(eo));
  endtask

  initial begin
    int ndone;
    logic [W-1:0] a;
    int n;
    bit r;

    #12;
    check("reset.out", int'(out), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.carry", int'(carry), 0);
    check("reset.ovf", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h81, 1, 1'b0, "t1");
    run_op(8'h01, 7, 1'b0, "t2");
    run_op(8'h5A, 0, 1'b0, "t3");

    // A second start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; in_v = 8'h0F; amt_v = 3'd3; rot_v = 1'b0;
    @(negedge clk);
    in_v = 8'hFF; amt_v = 3'd1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        ndone++;
        check("t4.out", int'(out), 8'h78);
        check("t4.carry", int'(carry), 0);
        check("t4.ovf", int'(overflow), 0);
      end
      @(negedge clk);
    end
    check("t4.done_pulses", ndone, 1);

    // An asynchronous reset in the middle of an operation discards it.
    @(negedge clk);
    start = 1'b1; in_v = 8'hC3; amt_v = 3'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5.out", int'(out), 0);
    check("t5.busy", int'(busy), 0);
    check("t5.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 2, 1'b0, "t5b");

`ifdef SEQ_SHIFT_ROTATE_EN
    run_op(8'h81, 1, 1'b1, "t6rot");
    run_op(8'h81, 1, 1'b0, "t6log");
`endif

    for (int k = 0; k < 40; k++) begin
      a = W'($urandom);
      n = int'($urandom_range(0, W - 1));
`ifdef SEQ_SHIFT_ROTATE_EN
      r = 1'($urandom);
`else
      r = 1'b0;
`endif
      run_op(a, n, r, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_seq_left_shifter
